// File: rtl/colsum_pkg.sv
// rtl/colsum_pkg.sv - shared widths, saturation limits and FSM encoding for the column-sum sequencer
package colsum_pkg;

  // Width of one signed PE row output
  localparam int ROW_W = 16;
  // Full-precision width of a three-row sum (3 x 16-bit signed never overflows 18 bits)
  localparam int SUM_W = 18;
  // Saturated bytes packed into one output word
  localparam int LANES = 4;
  // Lane index width
  localparam int LANE_W = $clog2(LANES);

  // int8 saturation limits
  localparam logic signed [7:0] SAT_MAX = 8'sh7F;
  localparam logic signed [7:0] SAT_MIN = 8'sh80;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Pack four lane bytes into one word, lane 0 in the low byte
  function automatic logic [31:0] pack_lanes(input logic [7:0] b3, input logic [7:0] b2,
                                             input logic [7:0] b1, input logic [7:0] b0);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/colsum_if.sv
// rtl/colsum_if.sv - input and output stream signals of the column-sum sequencer
interface colsum_if;
  import colsum_pkg::*;

  // Input stream: {row3, row2, row1} per column
  logic [3*ROW_W-1:0] s_tdata;
  logic               s_tvalid;
  logic               s_tready;

  // Output stream: four packed saturated column sums
  logic [31:0]        m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;

  // Producer of column data and consumer of packed words
  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );

  // The sequencer itself
  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/colsum_sat.sv
// rtl/colsum_sat.sv - three-row signed sum with int8 saturation and a saturation flag
module colsum_sat
  import colsum_pkg::*;
(
  input  logic signed [ROW_W-1:0] row1,
  input  logic signed [ROW_W-1:0] row2,
  input  logic signed [ROW_W-1:0] row3,
  output logic        [7:0]       sat_byte,
  output logic                    sat_flag
);

  localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0] SUM_LO = SUM_W'(SAT_MIN);

  logic signed [SUM_W-1:0] sum;

  // Sign-extend every row before adding so the range check sees the exact sum
  always_comb begin
    sum = $signed({{(SUM_W-ROW_W){row1[ROW_W-1]}}, row1})
        + $signed({{(SUM_W-ROW_W){row2[ROW_W-1]}}, row2})
        + $signed({{(SUM_W-ROW_W){row3[ROW_W-1]}}, row3});
    sat_flag = 1'b0;
    sat_byte = sum[7:0];
    if (sum > SUM_HI) begin
      sat_byte = SAT_MAX;
      sat_flag = 1'b1;
    end else if (sum < SUM_LO) begin
      sat_byte = SAT_MIN;
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/colsum_sequencer.sv
// rtl/colsum_sequencer.sv - frames column sums into packed int8 words; COLSUM_SAT_CNT_EN adds sat_cnt
module colsum_sequencer
  import colsum_pkg::*;
#(
  parameter int NUM_COLS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  colsum_if.slave    axis
`ifdef COLSUM_SAT_CNT_EN
  ,
  output logic [15:0] sat_cnt
`endif
);

  localparam logic [15:0]       COL_LAST  = 16'(NUM_COLS - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  state_t            state;
  logic [LANE_W-1:0] lane;
  logic [15:0]       col_cnt;
  logic [7:0]        stage0;
  logic [7:0]        stage1;
  logic [7:0]        stage2;
  logic [31:0]       m_data_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0]        sat_byte;
  logic              sat_flag;
  logic              s_ready_c;
  logic              beat_acc;
  logic              word_acc;
  logic              last_beat;
  logic              start_acc;

  colsum_sat u_sat (
    .row1     (axis.s_tdata[ROW_W-1:0]),
    .row2     (axis.s_tdata[2*ROW_W-1:ROW_W]),
    .row3     (axis.s_tdata[3*ROW_W-1:2*ROW_W]),
    .sat_byte (sat_byte),
    .sat_flag (sat_flag)
  );

  // The lane-3 beat completes a word, so it may only enter when the output slot is free or draining
  always_comb begin
    s_ready_c = (state == ST_RUN) && ((lane != LANE_LAST) || !m_valid_q || axis.m_tready);
    beat_acc  = axis.s_tvalid && s_ready_c;
    word_acc  = m_valid_q && axis.m_tready;
    last_beat = (col_cnt == COL_LAST);
    start_acc = (state == ST_IDLE) && start;
  end

  // Frame FSM with lane staging and the output word register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lane      <= '0;
      col_cnt   <= '0;
      stage0    <= '0;
      stage1    <= '0;
      stage2    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // A drained word frees the slot; a same-cycle load below overrides this
      if (word_acc) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      if (beat_acc) begin
        lane    <= lane + LANE_W'(1);
        col_cnt <= col_cnt + 16'd1;
        case (lane)
          2'd0:    stage0 <= sat_byte;
          2'd1:    stage1 <= sat_byte;
          2'd2:    stage2 <= sat_byte;
          default: begin
            m_data_q  <= pack_lanes(sat_byte, stage2, stage1, stage0);
            m_valid_q <= 1'b1;
            m_last_q  <= last_beat;
          end
        endcase
      end

      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            lane    <= '0;
            col_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (beat_acc && last_beat) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (word_acc && m_last_q) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef COLSUM_SAT_CNT_EN
  // Saturation event counter: restarts with each frame and sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (start_acc) begin
      sat_cnt <= '0;
    end else if (beat_acc && sat_flag && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_flag ^ start_acc;
`endif

  assign axis.s_tready = s_ready_c;
  assign axis.m_tdata  = m_data_q;
  assign axis.m_tvalid = m_valid_q;
  assign axis.m_tlast  = m_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_colsum_sequencer.sv
// tb/tb_colsum_sequencer.sv - self-checking bench for colsum_sequencer (NUM_COLS 4 and 16) and colsum_sat
module tb_colsum_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st    [2];
  logic [47:0] sd    [2];
  logic        sv    [2];
  logic        mr    [2];
  logic        busy_w[2];
  logic        done_w[2];
  logic        srdy  [2];
  logic        mv    [2];
  logic        ml    [2];
  logic [31:0] md    [2];
  logic [15:0] satw  [2];

  int n_chk  = 0;
  int n_fail = 0;

  colsum_if if0();
  colsum_if if1();

  assign if0.s_tdata  = sd[0];
  assign if0.s_tvalid = sv[0];
  assign if0.m_tready = mr[0];
  assign srdy[0]      = if0.s_tready;
  assign mv[0]        = if0.m_tvalid;
  assign ml[0]        = if0.m_tlast;
  assign md[0]        = if0.m_tdata;
  assign if1.s_tdata  = sd[1];
  assign if1.s_tvalid = sv[1];
  assign if1.m_tready = mr[1];
  assign srdy[1]      = if1.s_tready;
  assign mv[1]        = if1.m_tvalid;
  assign ml[1]        = if1.m_tlast;
  assign md[1]        = if1.m_tdata;

  colsum_sequencer #(.NUM_COLS(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (st[0]),
    .busy  (busy_w[0]),
    .done  (done_w[0]),
    .axis  (if0)
`ifdef COLSUM_SAT_CNT_EN
    ,
    .sat_cnt (satw[0])
`endif
  );

  colsum_sequencer #(.NUM_COLS(16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (st[1]),
    .busy  (busy_w[1]),
    .done  (done_w[1]),
    .axis  (if1)
`ifdef COLSUM_SAT_CNT_EN
    ,
    .sat_cnt (satw[1])
`endif
  );

`ifndef COLSUM_SAT_CNT_EN
  assign satw[0] = '0;
  assign satw[1] = '0;
`endif

  logic signed [15:0] u1, u2, u3;
  logic [7:0]         ub;
  logic               uf;

  colsum_sat u_sat (
    .row1     (u1),
    .row2     (u2),
    .row3     (u3),
    .sat_byte (ub),
    .sat_flag (uf)
  );

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] b(input int r1, input int r2, input int r3);
    return {16'(r3), 16'(r2), 16'(r1)};
  endfunction

  // Reference arithmetic: exact integer sum, then clamp to int8
  task automatic model_sat(input logic [47:0] v, output logic [7:0] by, output bit f);
    int s;
    s = int'($signed(v[15:0])) + int'($signed(v[31:16])) + int'($signed(v[47:32]));
    f = 1'b0;
    if (s > 127) begin
      by = 8'h7F; f = 1'b1;
    end else if (s < -128) begin
      by = 8'h80; f = 1'b1;
    end else begin
      by = 8'(s);
    end
  endtask

  // Frame model: phase 0 idle, 1 accepting columns, 2 waiting for last word, 3 done pulse
  int          phase [2] = '{0, 0};
  int          beats [2] = '{0, 0};
  int          satc  [2] = '{0, 0};
  bit          zchk  [2] = '{0, 0};
  int          ncols [2] = '{4, 16};
  logic [7:0]  bytes [2][4];
  logic [32:0] exp0[$], exp1[$];
  logic [32:0] rx0[$],  rx1[$];

  // Compare process: check outputs against the model, then advance the model by the coming edge
  always @(negedge clk) begin
    int          qs;
    logic [32:0] fr;
    logic [7:0]  by;
    bit          f, xfer, lastx, rdy_exp;
    for (int d = 0; d < 2; d++) begin
      qs = (d == 0) ? exp0.size() : exp1.size();
      fr = '0;
      if (qs != 0) fr = (d == 0) ? exp0[0] : exp1[0];

      if (zchk[d]) begin
        chk({busy_w[d], done_w[d], srdy[d], mv[d], ml[d], md[d], satw[d]} == '0, "reset_outputs_zero",
            {busy_w[d], done_w[d], srdy[d], mv[d], ml[d], md[d], satw[d]}, 0);
        zchk[d] = 1'b0;
      end
      chk(busy_w[d] == (phase[d] == 1 || phase[d] == 2), "busy", busy_w[d], (phase[d] == 1 || phase[d] == 2));
      chk(done_w[d] == (phase[d] == 3), "done", done_w[d], (phase[d] == 3));
      rdy_exp = (phase[d] == 1) && ((beats[d] % 4 != 3) || !mv[d] || mr[d]);
      chk(srdy[d] == rdy_exp, "s_tready", srdy[d], rdy_exp);
      chk(mv[d] == (qs != 0), "m_tvalid", mv[d], (qs != 0));
      if (mv[d] && qs != 0) chk({ml[d], md[d]} == fr, "m_word", {ml[d], md[d]}, fr);
`ifdef COLSUM_SAT_CNT_EN
      chk(satw[d] == 16'(satc[d]), "sat_cnt", satw[d], satc[d]);
`endif

      if (rst) begin
        phase[d] = 0; beats[d] = 0; satc[d] = 0; zchk[d] = 1'b1;
        if (d == 0) exp0.delete(); else exp1.delete();
      end else begin
        xfer  = mv[d] && mr[d];
        lastx = xfer && ml[d];
        if (xfer && qs != 0) begin
          if (d == 0) begin void'(exp0.pop_front()); rx0.push_back({ml[d], md[d]}); end
          else begin void'(exp1.pop_front()); rx1.push_back({ml[d], md[d]}); end
        end
        case (phase[d])
          0: if (st[d]) begin phase[d] = 1; beats[d] = 0; satc[d] = 0; end
          1: if (sv[d] && srdy[d]) begin
               model_sat(sd[d], by, f);
               bytes[d][beats[d] % 4] = by;
               if (f && satc[d] < 65535) satc[d]++;
               beats[d]++;
               if (beats[d] % 4 == 0) begin
                 if (d == 0) exp0.push_back({beats[d] == ncols[d], bytes[d][3], bytes[d][2], bytes[d][1], bytes[d][0]});
                 else        exp1.push_back({beats[d] == ncols[d], bytes[d][3], bytes[d][2], bytes[d][1], bytes[d][0]});
               end
               if (beats[d] == ncols[d]) phase[d] = 2;
             end
          2: if (lastx) phase[d] = 3;
          default: phase[d] = 0;
        endcase
      end
    end
  end

  task automatic pulse_start(input int d);
    st[d] = 1'b1;
    @(posedge clk); #1;
    st[d] = 1'b0;
  endtask

  task automatic send_beat(input int d, input logic [47:0] v);
    bit ok;
    ok = 1'b0;
    sd[d] = v;
    sv[d] = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (srdy[d]) begin ok = 1'b1; break; end
    end
    if (!ok) chk(ok, "s_handshake_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int d, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_w[d]) begin seen = 1'b1; break; end
    end
    chk(seen, "done_seen", seen, 1);
    @(posedge clk); #1;
  endtask

  int tr1[6] = '{32767, -32768, 100, 100, -128, -129};
  int tr2[6] = '{32767, -32768, 27, 28, 0, 0};
  int tr3[6] = '{32767, -32768, 0, 0, 0, 0};
  int texp[6] = '{'h7F, 'h80, 'h7F, 'h7F, 'h80, 'h80};
  int tfl[6]  = '{1, 1, 0, 1, 0, 1};
  bit got;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; sv[d] = 1'b0; sd[d] = '0; mr[d] = 1'b1;
    end
    u1 = '0; u2 = '0; u3 = '0;

    // Saturation boundaries on the arithmetic unit alone
    for (int i = 0; i < 6; i++) begin
      u1 = 16'(tr1[i]); u2 = 16'(tr2[i]); u3 = 16'(tr3[i]);
      #1;
      chk(ub == 8'(texp[i]), "sat_byte", ub, texp[i]);
      chk(uf == tfl[i][0], "sat_flag", uf, tfl[i]);
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk({busy_w[1], done_w[1], srdy[1], mv[1], ml[1], md[1]} == '0, "reset_state",
        {busy_w[1], done_w[1], srdy[1], mv[1], ml[1], md[1]}, 0);

    // One-word frame on the 4-column instance
    pulse_start(0);
    send_beat(0, b(10, 20, 30));
    send_beat(0, b(1, 1, 1));
    send_beat(0, b(-5, 0, 0));
    send_beat(0, b(0, 0, 0));
    sv[0] = 1'b0;
    wait_done(0, 50);
    chk(rx0.size() == 1, "frame4_word_count", rx0.size(), 1);
    if (rx0.size() == 1) chk(rx0[0] == {1'b1, 32'h00FB033C}, "frame4_word", rx0[0], {1'b1, 32'h00FB033C});

    // Saturating beats plus a 20-cycle output stall on the 16-column instance
    rx1.delete();
    mr[1] = 1'b0;
    pulse_start(1);
    fork
      begin
        send_beat(1, b(32767, 32767, 32767));
        send_beat(1, b(-32768, -32768, -32768));
        send_beat(1, b(100, 27, 0));
        send_beat(1, b(-128, 0, 0));
        for (int k = 4; k < 16; k++) send_beat(1, b(k, 2 * k, -k));
        sv[1] = 1'b0;
      end
      begin
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (mv[1]) begin got = 1'b1; break; end
        end
        chk(got, "word1_appears", got, 1);
        repeat (20) @(negedge clk);
        chk(srdy[1] == 1'b0, "s_tready_stalled", srdy[1], 0);
        chk(mv[1] && md[1] == 32'h807F807F, "word1_held", {mv[1], md[1]}, {1'b1, 32'h807F807F});
        @(posedge clk); #1;
        mr[1] = 1'b1;
      end
    join
    wait_done(1, 200);
    chk(rx1.size() == 4, "stall_word_count", rx1.size(), 4);
    if (rx1.size() == 4) begin
      chk(rx1[0][31:0] == 32'h807F807F, "stall_word1", rx1[0][31:0], 32'h807F807F);
      chk(rx1[1][31:0] == 32'h0E0C0A08, "stall_word2", rx1[1][31:0], 32'h0E0C0A08);
      for (int i = 0; i < 4; i++) chk(rx1[i][32] == (i == 3), "stall_tlast", rx1[i][32], (i == 3));
    end
`ifdef COLSUM_SAT_CNT_EN
    chk(satw[1] == 16'd2, "sat_cnt_frame", satw[1], 2);
`endif

    // Reset after beat 6 discards the frame; a fresh frame then completes
    pulse_start(1);
    for (int k = 1; k <= 6; k++) send_beat(1, b(k, 0, 0));
    sv[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({busy_w[1], done_w[1], mv[1], ml[1], md[1]} == '0, "after_rst", {busy_w[1], done_w[1], mv[1], ml[1], md[1]}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(done_w[1] == 1'b0, "no_done_after_rst", done_w[1], 0);
    end
    @(posedge clk); #1;
    rx1.delete();
    pulse_start(1);
    for (int k = 0; k < 16; k++) send_beat(1, b(k, k, k));
    sv[1] = 1'b0;
    wait_done(1, 50);
    chk(rx1.size() == 4, "post_rst_word_count", rx1.size(), 4);
    if (rx1.size() == 4) begin
      chk(rx1[0] == {1'b0, 32'h09060300}, "post_rst_word1", rx1[0], {1'b0, 32'h09060300});
      chk(rx1[3] == {1'b1, 32'h2D2A2724}, "post_rst_word4", rx1[3], {1'b1, 32'h2D2A2724});
    end

    // Start pulsed mid-frame must not restart the frame
    rx1.delete();
    pulse_start(1);
    for (int k = 0; k < 5; k++) send_beat(1, b(k, 0, 0));
    st[1] = 1'b1;
    send_beat(1, b(5, 0, 0));
    st[1] = 1'b0;
    for (int k = 6; k < 16; k++) send_beat(1, b(k, 0, 0));
    sv[1] = 1'b0;
    wait_done(1, 50);
    chk(rx1.size() == 4, "restart_word_count", rx1.size(), 4);
    if (rx1.size() == 4) chk(rx1[3] == {1'b1, 32'h0F0E0D0C}, "restart_word4", rx1[3], {1'b1, 32'h0F0E0D0C});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(done_w[1] == 1'b0, "single_done", done_w[1], 0);
    end
`ifdef COLSUM_SAT_CNT_EN
    chk(satw[1] == 16'd0, "sat_cnt_clean", satw[1], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
